// File: rtl/coin_payer_pkg.sv
// ============================================================================
// Module   : coin_payer_pkg
// Purpose  : Shared constants and helpers for the coin_payer initiator:
//            one-hot state encoding, coin values and the coin-choice rule.
// Config   : COIN_PAYER_OVERPAY_EN selects the overpaying coin rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package coin_payer_pkg;

    // One-hot FSM state encoding
    localparam logic [4:0] IDLE = 5'b00001;
    localparam logic [4:0] SEND = 5'b00010;
    localparam logic [4:0] GAP  = 5'b00100;
    localparam logic [4:0] WAIT = 5'b01000;
    localparam logic [4:0] DONE = 5'b10000;

    // Coin values in half-unit steps
    localparam logic [4:0] HALF = 5'd1;
    localparam logic [4:0] ONE  = 5'd2;

    // Returns 1 when the next coin should be a one-unit coin.
    function automatic logic pick_one(input logic [4:0] rem, input logic pref_one);
`ifdef COIN_PAYER_OVERPAY_EN
        // Always pay with one-unit coins; the final coin may overpay by a half.
        return pref_one && (rem != 5'd0);
`else
        // Never send a one-unit coin when only a half remains: exact payment.
        return pref_one && (rem >= 5'd2);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/coin_payer_timer.sv
// ============================================================================
// Module   : payer_timer
// Purpose  : Loadable 8-bit down-counter with zero flag, shared by the
//            inter-coin gap and the beverage wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module payer_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;

    // Load has priority over decrement; the count holds at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

`default_nettype wire

// File: rtl/coin_payer.sv
// ============================================================================
// Module   : coin_payer
// Purpose  : Customer-side initiator for the vending-machine coin interface.
//            Emits one-cycle coin pulses until the price is paid, waits for
//            the beverage and change pulses, and keeps saturating counts of
//            beverages and change received.
// Config   : COIN_PAYER_OVERPAY_EN - with pref_one, always pay one-unit
//            coins (may overpay by one half, one change pulse expected).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_payer
    import coin_payer_pkg::*;
#(
    parameter int PRICE_HALVES = 3,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 8,
    parameter int CNT_W        = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             buy_req,
    input  logic             buy_pref_one,
    output logic             po_money_one,
    output logic             po_money_half,
    input  logic             pi_beverage,
    input  logic             pi_money,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_change,
    output logic [CNT_W-1:0] vend_cnt,
    output logic [CNT_W-1:0] change_cnt
);

    localparam logic [4:0]       PRICE_LD = 5'(PRICE_HALVES);
    // GAP timer counts down to zero, so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [7:0]       GAP_LD   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]       WAIT_LD  = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);

    logic [4:0] state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic       pref_q, pref_d;
    logic       over_q, over_d;      // last coin overpaid: one change pulse expected
    logic       one_q, one_d;
    logic       half_q, half_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       eto_q, eto_d;
    logic       ech_q, ech_d;
    logic [CNT_W-1:0] vend_q, chg_q;

    logic       tmr_load, tmr_dec, tmr_zero;
    logic [7:0] tmr_val;

    logic       send_coin, coin_is_one, coin_pref;
    logic [4:0] coin_rem, coin_val;

    payer_timer u_timer (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state, coin selection and output pulse decode.
    // A coin is registered on the edge entering SEND so it is visible during SEND.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pref_d      = pref_q;
        over_d      = over_q;
        one_d       = 1'b0;
        half_d      = 1'b0;
        done_d      = 1'b0;
        eto_d       = 1'b0;
        ech_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = 8'd0;
        tmr_dec     = 1'b0;
        send_coin   = 1'b0;
        coin_rem    = rem_q;
        coin_pref   = pref_q;
        coin_is_one = 1'b0;
        coin_val    = HALF;

        case (state_q)
            IDLE: begin
                if (buy_req) begin
                    state_d   = SEND;
                    pref_d    = buy_pref_one;
                    over_d    = 1'b0;
                    coin_rem  = PRICE_LD;
                    coin_pref = buy_pref_one;
                    send_coin = 1'b1;
                end
            end
            SEND: begin
                if (rem_q != 5'd0) begin
                    if (GAP_CYCLES == 0) begin
                        send_coin = 1'b1;
                    end else begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end
                end else begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = WAIT_LD;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d   = SEND;
                    send_coin = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WAIT: begin
                if (pi_beverage) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ech_d   = (pi_money != over_q);
                end else if (tmr_zero) begin
                    state_d = IDLE;
                    eto_d   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (send_coin) begin
            state_d     = SEND;
            coin_is_one = pick_one(coin_rem, coin_pref);
            coin_val    = coin_is_one ? ONE : HALF;
            one_d       = coin_is_one;
            half_d      = !coin_is_one;
            if (coin_val > coin_rem) begin
                rem_d  = 5'd0;
                over_d = 1'b1;
            end else begin
                rem_d  = coin_rem - coin_val;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any purchase in progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            rem_q   <= 5'd0;
            pref_q  <= 1'b0;
            over_q  <= 1'b0;
            one_q   <= 1'b0;
            half_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eto_q   <= 1'b0;
            ech_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pref_q  <= pref_d;
            over_q  <= over_d;
            one_q   <= one_d;
            half_q  <= half_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eto_q   <= eto_d;
            ech_q   <= ech_d;
        end
    end

    // Saturating counts of every beverage / change pulse, in any state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vend_q <= '0;
            chg_q  <= '0;
        end else begin
            if (pi_beverage && (vend_q != '1)) begin
                vend_q <= vend_q + CNT_INC;
            end
            if (pi_money && (chg_q != '1)) begin
                chg_q <= chg_q + CNT_INC;
            end
        end
    end

    assign po_money_one  = one_q;
    assign po_money_half = half_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_timeout   = eto_q;
    assign err_change    = ech_q;
    assign vend_cnt      = vend_q;
    assign change_cnt    = chg_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_payer.sv
// ============================================================================
// Module   : tb_coin_payer
// Purpose  : Directed self-checking bench for coin_payer
//            (PRICE_HALVES=3, GAP_CYCLES=2, TIMEOUT=8, CNT_W=8).
//            Honours COIN_PAYER_OVERPAY_EN when defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coin_payer;

    localparam int G = 2;

    logic       sys_clk      = 1'b0;
    logic       sys_rst      = 1'b1;
    logic       buy_req      = 1'b0;
    logic       buy_pref_one = 1'b0;
    logic       pi_beverage  = 1'b0;
    logic       pi_money     = 1'b0;
    logic       po_money_one, po_money_half, busy, done, err_timeout, err_change;
    logic [7:0] vend_cnt, change_cnt;

    int n_vec    = 0;
    int n_bad    = 0;
    int exp_vend = 0;
    int exp_chg  = 0;

    always #5 sys_clk = ~sys_clk;

    coin_payer #(
        .PRICE_HALVES (3),
        .GAP_CYCLES   (G),
        .TIMEOUT      (8),
        .CNT_W        (8)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .buy_req       (buy_req),
        .buy_pref_one  (buy_pref_one),
        .po_money_one  (po_money_one),
        .po_money_half (po_money_half),
        .pi_beverage   (pi_beverage),
        .pi_money      (pi_money),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .err_change    (err_change),
        .vend_cnt      (vend_cnt),
        .change_cnt    (change_cnt)
    );

    // Advance one cycle and settle past the active edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Order: {one, half, busy, done, err_timeout, err_change}
    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {2'b00, po_money_one, po_money_half, busy, done, err_timeout, err_change},
            {2'b00, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_vend"}, vend_cnt, 8'(exp_vend));
        chk({tag, "_chg"}, change_cnt, 8'(exp_chg));
    endtask

    // Called in the first coin cycle; checks every coin and the idle gaps.
    // Bit k of is_one: coin k is a one-unit coin. Returns in the last coin cycle.
    task automatic coin_seq(input string tag, input logic [2:0] is_one, input int ncoins);
        for (int k = 0; k < ncoins; k++) begin
            chk_out($sformatf("%s_coin%0d", tag, k), {is_one[k], !is_one[k], 4'b1000});
            if (k < ncoins - 1) begin
                for (int g = 0; g < G; g++) begin
                    tick();
                    chk_out($sformatf("%s_gap%0d_%0d", tag, k, g), 6'b001000);
                end
                tick();
            end
        end
    endtask

    // From the last coin cycle: beverage in the first WAIT cycle, then DONE and IDLE.
    task automatic finish_buy(input string tag, input logic money, input logic exp_ech);
        tick();
        pi_beverage = 1'b1;
        pi_money    = money;
        if (exp_vend < 255) exp_vend++;
        if (money && exp_chg < 255) exp_chg++;
        tick();
        pi_beverage = 1'b0;
        pi_money    = 1'b0;
        chk_out({tag, "_done"}, {4'b0011, 1'b0, exp_ech});
        chk_cnt(tag);
        tick();
        chk_out({tag, "_idle"}, 6'b000000);
    endtask

    task automatic start_buy(input logic pref);
        buy_req      = 1'b1;
        buy_pref_one = pref;
        tick();
        buy_req      = 1'b0;
        buy_pref_one = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_out("rst", 6'b000000);
        chk_cnt("rst");
        sys_rst = 1'b0;
        tick();
        chk_out("rst_rel", 6'b000000);

        // Case 1: three half coins, exact payment, no change
        start_buy(1'b0);
        coin_seq("c1", 3'b000, 3);
        finish_buy("c1", 1'b0, 1'b0);

        // Case 2/3: prefer one-unit coins
`ifdef COIN_PAYER_OVERPAY_EN
        start_buy(1'b1);
        coin_seq("c3", 3'b011, 2);
        finish_buy("c3", 1'b1, 1'b0);
        // Overpaid but no change returned
        start_buy(1'b1);
        coin_seq("c3m", 3'b011, 2);
        finish_buy("c3m", 1'b0, 1'b1);
`else
        start_buy(1'b1);
        coin_seq("c2", 3'b001, 2);
        finish_buy("c2", 1'b0, 1'b0);
`endif

        // Unexpected change on an exact payment
        start_buy(1'b0);
        coin_seq("chg", 3'b000, 3);
        finish_buy("chg", 1'b1, 1'b1);

        // Case 4: no beverage -> timeout after TIMEOUT WAIT cycles
        start_buy(1'b0);
        coin_seq("c4", 3'b000, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("c4_wait%0d", i), 6'b001000);
        end
        tick();
        chk_out("c4_to", 6'b000010);
        chk_cnt("c4");
        tick();
        chk_out("c4_idle", 6'b000000);

        // Case 5: reset while the second coin is on the wire
        start_buy(1'b0);
        chk_out("c5_coin0", 6'b011000);
        tick();
        tick();
        tick();
        chk_out("c5_coin1", 6'b011000);
        sys_rst = 1'b1;
        tick();
        sys_rst  = 1'b0;
        exp_vend = 0;
        exp_chg  = 0;
        chk_out("c5_rst", 6'b000000);
        chk_cnt("c5_rst");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out($sformatf("c5_quiet%0d", i), 6'b000000);
        end
        start_buy(1'b0);
        coin_seq("c5r", 3'b000, 3);
        finish_buy("c5r", 1'b0, 1'b0);

        // Case 6: buy_req held high -> one purchase per IDLE entry
        buy_req = 1'b1;
        tick();
        coin_seq("c6", 3'b000, 3);
        finish_buy("c6", 1'b0, 1'b0);
        tick();
        chk_out("c6_rebuy", 6'b011000);
        buy_req = 1'b0;
        sys_rst = 1'b1;
        tick();
        sys_rst  = 1'b0;
        exp_vend = 0;
        exp_chg  = 0;
        chk_cnt("c6_rst");

        // Counter saturation on spurious pulses
        pi_beverage = 1'b1;
        pi_money    = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (exp_vend < 255) exp_vend++;
            if (exp_chg < 255) exp_chg++;
        end
        pi_beverage = 1'b0;
        pi_money    = 1'b0;
        tick();
        chk_cnt("sat");
        chk("sat_vend_ff", vend_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
